// File: rtl/fp_div_seq.sv
// Sequential single-precision divider, fp_Z = fp_X / fp_Y, radix-2 restoring (one quotient bit per clock).
// Subnormals flush to zero; special operands still take the full DIV pass so latency is constant.
module fp_div_seq #(
    parameter logic [31:0] NAN_VALUE = 32'h7FC0_0000,
    parameter int          QBITS     = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    input  logic [2:0]  r_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf
);

    // state | meaning
    // IDLE  | waiting for operands, in_ready=1
    // PREP  | classify operands, load remainder/divisor/counter/exponent
    // DIV   | one restoring-division step per clock, QBITS clocks
    // ROUND | normalise, round, override specials, register result
    // DONE  | result held with out_valid=1 until out_ready
    typedef enum logic [2:0] {IDLE, PREP, DIV, ROUND, DONE} state_t;

    state_t state_q, state_d;

    logic [31:0]       x_q, y_q;
    logic [2:0]        mode_q;
    logic              sign_q, spec_q;
    logic [31:0]       spec_z_q;
    logic signed [9:0] ez_q;
    logic [24:0]       rem_q;
    logic [23:0]       dm_q;
    logic [QBITS-1:0]  quo_q;
    logic [4:0]        cnt_q;

    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        case (state_q)
            IDLE:    if (in_valid) state_d = PREP;
            PREP:    state_d = DIV;
            DIV:     if (cnt_q == 5'd1) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic              x_zero, x_inf, x_nan, y_zero, y_inf, y_nan, prep_sign, prep_spec;
    logic [31:0]       prep_z;
    logic signed [9:0] prep_ez;

    always_comb begin
        x_zero    = (x_q[30:23] == 8'h00);
        y_zero    = (y_q[30:23] == 8'h00);
        x_inf     = (x_q[30:23] == 8'hFF) && (x_q[22:0] == 23'd0);
        y_inf     = (y_q[30:23] == 8'hFF) && (y_q[22:0] == 23'd0);
        x_nan     = (x_q[30:23] == 8'hFF) && (x_q[22:0] != 23'd0);
        y_nan     = (y_q[30:23] == 8'hFF) && (y_q[22:0] != 23'd0);
        prep_sign = x_q[31] ^ y_q[31];
        prep_ez   = $signed({2'b00, x_q[30:23]}) - $signed({2'b00, y_q[30:23]}) + 10'sd127;
        prep_spec = 1'b1;
        prep_z    = NAN_VALUE;
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
            prep_z = NAN_VALUE;
        end else if (x_inf || y_zero) begin
            prep_z = {prep_sign, 8'hFF, 23'd0};
        end else if (x_zero || y_inf) begin
            prep_z = {prep_sign, 31'd0};
        end else begin
            prep_spec = 1'b0;
        end
    end

    logic        q_bit;
    logic [24:0] diff, rem_sel, rem_d;

    always_comb begin
        q_bit   = (rem_q >= {1'b0, dm_q});
        diff    = rem_q - {1'b0, dm_q};
        rem_sel = q_bit ? diff : rem_q;
        rem_d   = rem_sel << 1;
    end

    logic              g_bit, s_bit, inc;
    logic [22:0]       frac_pre;
    logic signed [9:0] e_pre, e_post;
    logic [32:0]       packed_r;
    logic [31:0]       z_d;
    logic              ov_d, ud_d;

    always_comb begin
        if (quo_q[25]) begin
            frac_pre = quo_q[24:2];
            g_bit    = quo_q[1];
            s_bit    = quo_q[0] | (rem_q != 25'd0);
            e_pre    = ez_q;
        end else begin
            frac_pre = quo_q[23:1];
            g_bit    = quo_q[0];
            s_bit    = (rem_q != 25'd0);
            e_pre    = ez_q - 10'sd1;
        end
        case (mode_q)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sign_q & (g_bit | s_bit);
            3'b011:  inc = ~sign_q & (g_bit | s_bit);
            3'b100:  inc = g_bit;
            default: inc = g_bit & (s_bit | frac_pre[0]);
        endcase
        // A carry out of the fraction ripples into the exponent, giving 1.0 x 2^(e+1).
        packed_r = {e_pre, frac_pre} + {32'd0, inc};
        e_post   = $signed(packed_r[32:23]);
        ov_d     = 1'b0;
        ud_d     = 1'b0;
        z_d      = {sign_q, packed_r[30:0]};
        if (spec_q) begin
            z_d = spec_z_q;
        end else if (e_pre <= 10'sd0) begin
            z_d  = {sign_q, 31'd0};
            ud_d = 1'b1;
        end else if (e_post >= 10'sd255) begin
            ov_d = 1'b1;
            case (mode_q)
                3'b001:  z_d = {sign_q, 31'h7F7F_FFFF};
                3'b010:  z_d = sign_q ? 32'hFF80_0000 : 32'h7F7F_FFFF;
                3'b011:  z_d = sign_q ? 32'hFF7F_FFFF : 32'h7F80_0000;
                default: z_d = {sign_q, 31'h7F80_0000};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            mode_q   <= '0;
            sign_q   <= 1'b0;
            spec_q   <= 1'b0;
            spec_z_q <= '0;
            ez_q     <= '0;
            rem_q    <= '0;
            dm_q     <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            fp_Z     <= '0;
            ovrf     <= 1'b0;
            udrf     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q    <= fp_X;
                        y_q    <= fp_Y;
                        mode_q <= r_mode;
                    end
                end
                PREP: begin
                    sign_q   <= prep_sign;
                    spec_q   <= prep_spec;
                    spec_z_q <= prep_z;
                    ez_q     <= prep_ez;
                    rem_q    <= {2'b01, x_q[22:0]};
                    dm_q     <= {1'b1, y_q[22:0]};
                    quo_q    <= '0;
                    cnt_q    <= 5'(QBITS);
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= {quo_q[QBITS-2:0], q_bit};
                    cnt_q <= cnt_q - 5'd1;
                end
                ROUND: begin
                    fp_Z <= z_d;
                    ovrf <= ov_d;
                    udrf <= ud_d;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: vector table plus hand-written handshake/reset sequences.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] fp_X = '0;
    logic [31:0] fp_Y = '0;
    logic [2:0]  r_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] fp_Z;
    logic        ovrf;
    logic        udrf;

    int n_tests = 0;
    int n_fail  = 0;

    fp_div_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode), .out_valid(out_valid),
        .out_ready(out_ready), .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  m;
        logic [31:0] z;
        logic        ov;
        logic        ud;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        check("in_ready_before_start", {31'd0, in_ready}, 32'd1);
        fp_X     = x;
        fp_Y     = y;
        r_mode   = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        fp_X     = 32'hDEAD_BEEF;
        fp_Y     = 32'h1234_5678;
        r_mode   = 3'b011;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_release", {31'd0, in_ready}, 32'd1);
        check("out_valid_after_release", {31'd0, out_valid}, 32'd0);
    endtask

    int lat;
    logic saw_valid;

    initial begin
        vecs[0]  = '{32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 1'b0, 1'b0};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 1'b0, 1'b0};
        vecs[2]  = '{32'h3F800000, 32'h40400000, 3'b011, 32'h3EAAAAAB, 1'b0, 1'b0};
        vecs[3]  = '{32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 1'b0, 1'b0};
        vecs[4]  = '{32'h3F800000, 32'h40400000, 3'b010, 32'h3EAAAAAA, 1'b0, 1'b0};
        vecs[5]  = '{32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 1'b0, 1'b0};
        vecs[6]  = '{32'h3F800000, 32'h40400000, 3'b100, 32'h3EAAAAAB, 1'b0, 1'b0};
        vecs[7]  = '{32'h3F800000, 32'h40400000, 3'b111, 32'h3EAAAAAB, 1'b0, 1'b0};
        vecs[8]  = '{32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 1'b0, 1'b0};
        vecs[9]  = '{32'h00000000, 32'h00000000, 3'b000, 32'h7FC00000, 1'b0, 1'b0};
        vecs[10] = '{32'h7F800000, 32'hFF800000, 3'b000, 32'h7FC00000, 1'b0, 1'b0};
        vecs[11] = '{32'h00000001, 32'h3F800000, 3'b000, 32'h00000000, 1'b0, 1'b0};
        vecs[12] = '{32'h7F000000, 32'h3E800000, 3'b000, 32'h7F800000, 1'b1, 1'b0};
        vecs[13] = '{32'h7F000000, 32'h3E800000, 3'b001, 32'h7F7FFFFF, 1'b1, 1'b0};
        vecs[14] = '{32'h7F000000, 32'h3E800000, 3'b010, 32'h7F7FFFFF, 1'b1, 1'b0};
        vecs[15] = '{32'hFF000000, 32'h3E800000, 3'b011, 32'hFF7FFFFF, 1'b1, 1'b0};
        vecs[16] = '{32'h00800000, 32'h40000000, 3'b000, 32'h00000000, 1'b0, 1'b1};
        vecs[17] = '{32'h7FC00001, 32'h3F800000, 3'b000, 32'h7FC00000, 1'b0, 1'b0};
        vecs[18] = '{32'h80000000, 32'h7F800000, 3'b000, 32'h80000000, 1'b0, 1'b0};
        vecs[19] = '{32'hFF800000, 32'h40000000, 3'b000, 32'hFF800000, 1'b0, 1'b0};

        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_fp_Z", fp_Z, 32'd0);
        check("rst_flags", {30'd0, ovrf, udrf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            start_op(vecs[i].x, vecs[i].y, vecs[i].m);
            wait_result(lat);
            check($sformatf("vec%0d_latency", i), lat, 32'd28);
            check($sformatf("vec%0d_fp_Z", i), fp_Z, vecs[i].z);
            check($sformatf("vec%0d_ovrf", i), {31'd0, ovrf}, {31'd0, vecs[i].ov});
            check($sformatf("vec%0d_udrf", i), {31'd0, udrf}, {31'd0, vecs[i].ud});
            release_result();
        end

        // Backpressure: result held while out_ready low, new operands ignored.
        start_op(32'hC0C00000, 32'h40000000, 3'b000);
        wait_result(lat);
        check("bp_latency", lat, 32'd28);
        fp_X     = 32'h3F800000;
        fp_Y     = 32'h40400000;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_fp_Z", fp_Z, 32'hC0400000);
            check("bp_flags", {30'd0, ovrf, udrf}, 32'd0);
        end
        in_valid = 1'b0;
        release_result();
        saw_valid = 1'b0;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk);
            #1;
            saw_valid = saw_valid | out_valid;
        end
        check("bp_no_ghost_result", {31'd0, saw_valid}, 32'd0);

        // Release and new operand on the same DONE cycle: accepted one edge later.
        start_op(32'h3F800000, 32'h40400000, 3'b000);
        wait_result(lat);
        check("sim_first_z", fp_Z, 32'h3EAAAAAB);
        fp_X      = 32'h40C00000;
        fp_Y      = 32'h40000000;
        r_mode    = 3'b000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("sim_idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("sim_idle_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("sim_accepted", {31'd0, in_ready}, 32'd0);
        wait_result(lat);
        check("sim_latency", lat, 32'd28);
        check("sim_second_z", fp_Z, 32'h40400000);
        release_result();

        // Asynchronous reset in the middle of DIV.
        start_op(32'h3F800000, 32'h40400000, 3'b001);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_fp_Z", fp_Z, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            saw_valid = saw_valid | out_valid;
        end
        check("arst_no_stale_result", {31'd0, saw_valid}, 32'd0);
        start_op(32'h3F800000, 32'h40400000, 3'b001);
        wait_result(lat);
        check("arst_next_latency", lat, 32'd28);
        check("arst_next_z", fp_Z, 32'h3EAAAAAA);
        release_result();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Sequential single-precision IEEE-754 divider, fp_Z = fp_X / fp_Y.
- It is the inverse-operation companion of the FP multiplier in the ALU and follows the same number conventions: subnormals are flushed to zero, 3-bit r_mode, ovrf/udrf flags.
- Uses radix-2 restoring division (one quotient bit per clock) with valid/ready handshakes on both sides.
- Sits beside the multiplier in the ALU datapath.

Parameters:
- NAN_VALUE, 32'h7FC0_0000, canonical quiet NaN returned for every invalid or NaN case.
- QBITS, 26, quotient bits produced (24 mantissa bits + guard + 1 normalisation bit); fixed, not meant to be overridden.

Ports:
- clk        input   1   clock, rising edge.
- rst_n      input   1   asynchronous, active-low reset.
- in_valid   input   1   operands valid.
- in_ready   output  1   divider idle, can accept operands.
- fp_X       input   32  dividend.
- fp_Y       input   32  divisor.
- r_mode     input   3   000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 behave as RNE.
- out_valid  output  1   result valid.
- out_ready  input   1   consumer accepts result.
- fp_Z       output  32  quotient.
- ovrf       output  1   overflow flag, qualified by out_valid.
- udrf       output  1   underflow flag, qualified by out_valid.

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; fp_Z=0; ovrf=0; udrf=0; iteration counter=0. An operation in flight is discarded.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture fp_X, fp_Y and r_mode, then go to PREP. Later input changes are ignored.
  - PREP (1 cycle): unpack fields, classify operands, load the remainder with the dividend mantissa, load counter=QBITS, compute eZ = eX - eY + 127 (10-bit signed).
  - DIV (QBITS cycles): each cycle, if rem >= divisor mantissa, subtract and shift in q=1, else shift in q=0; shift rem left; decrement counter. Leave DIV when counter reaches 0.
  - ROUND (1 cycle): normalise, round, apply special-case override, register fp_Z/ovrf/udrf.
  - DONE: out_valid=1, outputs held stable. On out_ready go to IDLE. in_ready=0 in every state except IDLE.
- Latency: out_valid rises exactly QBITS+2 = 28 clock edges after the accepting edge. This holds for all inputs; special cases still traverse DIV. Throughput is one operation per 29+ cycles.
- Classification:
  - exp==0 is zero (mantissa ignored, sign kept).
  - exp==FF with mant!=0 is NaN.
  - exp==FF with mant==0 is Inf.
- Special-case results (priority order; ovrf=udrf=0 for all):
  - any NaN → NAN_VALUE.
  - 0/0 or Inf/Inf → NAN_VALUE.
  - Inf/x → signed Inf.
  - x/0 → signed Inf.
  - 0/x or x/Inf → signed zero.
  - Sign = sX^sY for every non-NaN result.
- Normal path:
  - Mantissas are 1.m (24 bits); quotient q[25:0].
  - If q[25]: mantissa=q[25:2], guard=q[1], sticky=q[0]|(rem!=0).
  - Else: mantissa=q[24:1], guard=q[0], sticky=(rem!=0), eZ=eZ-1.
  - Rounding increment:
    - RNE: g&(s|lsb).
    - RTZ: 0.
    - RDN: sign&(g|s).
    - RUP: !sign&(g|s).
    - RMM: g.
  - A mantissa carry-out on rounding sets mantissa=1.0 and eZ+1.
  - Underflow is judged on the pre-round eZ <= 0: fp_Z = signed zero, udrf=1.
  - Overflow is judged on the post-round eZ >= 255: ovrf=1. fp_Z = signed Inf for RNE/RMM; 0x7F7FFFFF with sign for RTZ; for RDN, max-finite if positive else -Inf; for RUP, +Inf if positive else max-finite.
- Simultaneous events:
  - in_valid while not IDLE is ignored (not captured).
  - In DONE, out_ready and in_valid in the same cycle: return to IDLE; the new operand is accepted on the following edge.

Test Plan:
- 0x40C00000 / 0x40000000, RNE → fp_Z=0x40400000, ovrf=udrf=0, out_valid exactly 28 edges after accept.
- 0x3F800000 / 0x40400000 → RNE and RUP give 0x3EAAAAAB; RTZ and RDN give 0x3EAAAAAA. Negated dividend 0xBF800000 with RDN gives 0xBEAAAAAB.
- Specials → 0x3F800000/0x00000000 gives 0x7F800000; 0/0 gives 0x7FC00000; 0x7F800000/0xFF800000 gives 0x7FC00000; subnormal 0x00000001/0x3F800000 gives 0x00000000; all with flags 0.
- 0x7F000000 / 0x3E800000 (2^129) → RNE gives 0x7F800000 with ovrf=1; RTZ gives 0x7F7FFFFF with ovrf=1. 0x00800000 / 0x40000000 → 0x00000000 with udrf=1.
- Backpressure: out_ready held low 10 cycles → fp_Z, ovrf, udrf and out_valid stable; in_ready=0; new in_valid ignored. The result is released on out_ready, and in_ready=1 the next cycle.
- rst_n pulsed low mid-DIV → out_valid=0 and in_ready=1 immediately (asynchronous); no stale result appears afterward; the next operation completes correctly.
